// File: rtl/tile_feeder_pkg.sv
// Shared types for the systolic-array tile feeder: FSM state encoding and
// the width of the optional statistics counters (TILE_FEEDER_CNT_EN).
package tile_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register delay line, cleared by synchronous reset.
module skew_line #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/tile_feeder.sv
// Skews A/B operand beats and the per-diagonal init wave into an NxN
// systolic array. Optional beat/bubble counters under TILE_FEEDER_CNT_EN.
module tile_feeder
  import tile_feeder_pkg::*;
#(
  parameter int unsigned D_W   = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned K_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N*D_W-1:0]   s_a,
  input  logic [N*D_W-1:0]   s_b,
  input  logic               flush,
  output logic [N*D_W-1:0]   a_out,
  output logic [N*D_W-1:0]   b_out,
  output logic [2*N-2:0]     init_out,
  output logic               tile_done,
  output logic               busy
`ifdef TILE_FEEDER_CNT_EN
  ,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  localparam int unsigned   KW     = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K_LEN - 1);

  state_t          r_state;
  logic [KW-1:0]   r_k_cnt;
  logic            r_tile_done;
  logic            w_xfer;
  logic            w_last;
  logic            w_tile_start;
  logic [N*D_W-1:0] w_a_in;
  logic [N*D_W-1:0] w_b_in;
  logic [2*N-1:0]  w_init_chain;

  // flush in IDLE takes priority, so the beat is held off combinationally
  assign s_ready      = !rst && ((r_state == STREAM) || (r_state == IDLE && !flush));
  assign w_xfer       = s_valid && s_ready;
  assign w_last       = w_xfer && (r_k_cnt == K_LAST);
  assign w_tile_start = (w_xfer && (r_k_cnt == '0)) || (r_state == FLUSH);
  assign w_a_in       = w_xfer ? s_a : '0;
  assign w_b_in       = w_xfer ? s_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k_cnt     <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= w_last;
      if (w_xfer) r_k_cnt <= w_last ? '0 : r_k_cnt + KW'(1);
      case (r_state)
        IDLE: begin
          if (flush)       r_state <= FLUSH;
          else if (w_xfer) r_state <= w_last ? IDLE : STREAM;
        end
        STREAM: if (w_last) r_state <= IDLE;
        FLUSH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.W(D_W), .DEPTH(i + 1)) u_a (
      .clk(clk), .rst(rst), .i_d(w_a_in[i*D_W +: D_W]), .o_q(a_out[i*D_W +: D_W])
    );
    skew_line #(.W(D_W), .DEPTH(i + 1)) u_b (
      .clk(clk), .rst(rst), .i_d(w_b_in[i*D_W +: D_W]), .o_q(b_out[i*D_W +: D_W])
    );
  end

  // init wave: each diagonal sees the tile-start one cycle after its predecessor
  assign w_init_chain[0] = w_tile_start;
  for (genvar d = 0; d < 2*N-1; d++) begin : g_init
    skew_line #(.W(1), .DEPTH(1)) u_init (
      .clk(clk), .rst(rst), .i_d(w_init_chain[d]), .o_q(w_init_chain[d+1])
    );
  end

  assign init_out  = w_init_chain[2*N-1:1];
  assign tile_done = r_tile_done;
  assign busy      = (r_state != IDLE) || (|init_out);

`ifdef TILE_FEEDER_CNT_EN
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_xfer) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (r_state == STREAM && !w_xfer) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign beat_cnt   = r_beat_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_tile_feeder.sv
// Scoreboard bench for tile_feeder (N=4, K_LEN=3, D_W=32); counter ports
// are checked when TILE_FEEDER_CNT_EN is defined.
module tb_tile_feeder;

  localparam int DW   = 32;
  localparam int NN   = 4;
  localparam int KL   = 3;
  localparam int MAXC = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              flush = 1'b0;
  logic              s_ready;
  logic [NN*DW-1:0]  s_a = '0;
  logic [NN*DW-1:0]  s_b = '0;
  logic [NN*DW-1:0]  a_out;
  logic [NN*DW-1:0]  b_out;
  logic [2*NN-2:0]   init_out;
  logic              tile_done;
  logic              busy;
`ifdef TILE_FEEDER_CNT_EN
  logic [31:0]       beat_cnt;
  logic [31:0]       bubble_cnt;
`endif

  tile_feeder #(.D_W(DW), .N(NN), .K_LEN(KL)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .flush(flush),
    .a_out(a_out), .b_out(b_out), .init_out(init_out),
    .tile_done(tile_done), .busy(busy)
`ifdef TILE_FEEDER_CNT_EN
    , .beat_cnt(beat_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               chk;
    int               cyc;
    logic             rdy;
    logic [NN*DW-1:0] a;
    logic [NN*DW-1:0] b;
    logic [2*NN-2:0]  init;
    logic             done;
    logic             bsy;
    logic [31:0]      bc;
    logic [31:0]      bb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per-cycle history of what entered the array edge.
  logic [NN*DW-1:0] inj_a [MAXC];
  logic [NN*DW-1:0] inj_b [MAXC];
  bit               start_h [MAXC];
  bit               last_h [MAXC];
  int               cyc = 0;
  int               last_rst = -1;
  int               mst = 0;   // 0 idle, 1 mid-tile, 2 flush cycle
  int               mk = 0;
  int               m_beats = 0;
  int               m_bubbles = 0;

  function automatic bit live(input int idx);
    return idx >= 0 && idx > last_rst;
  endfunction

  function automatic logic [NN*DW-1:0] vec(input int x0, input int x1, input int x2, input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  task automatic step(input logic r, input logic v, input logic f,
                      input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
    exp_t e;
    bit   rdy, xfer, st, lst;
    @(posedge clk);
    #2;
    rst = r; s_valid = v; flush = f; s_a = a; s_b = b;
    e.chk = (cyc > 0);
    e.cyc = cyc;
    e.a = '0; e.b = '0; e.init = '0;
    for (int i = 0; i < NN; i++) begin
      if (live(cyc - 1 - i)) begin
        e.a[i*DW +: DW] = inj_a[cyc-1-i][i*DW +: DW];
        e.b[i*DW +: DW] = inj_b[cyc-1-i][i*DW +: DW];
      end
    end
    for (int d = 0; d < 2*NN-1; d++)
      e.init[d] = live(cyc - 1 - d) && start_h[cyc-1-d];
    e.done = live(cyc - 1) && last_h[cyc-1];
    e.bsy  = (mst != 0) || (|e.init);
    e.bc   = 32'(m_beats);
    e.bb   = 32'(m_bubbles);
    if (r) begin
      rdy = 0; xfer = 0; st = 0; lst = 0;
      mst = 0; mk = 0; m_beats = 0; m_bubbles = 0;
      last_rst = cyc;
    end else begin
      rdy  = (mst == 1) || (mst == 0 && !f);
      xfer = v && rdy;
      st   = (xfer && mk == 0) || (mst == 2);
      lst  = xfer && (mk == KL - 1);
      if (xfer) m_beats++;
      if (mst == 1 && !xfer) m_bubbles++;
      if (mst == 0 && f) mst = 2;
      else if (mst == 2) mst = 0;
      else if (xfer) mst = lst ? 0 : 1;
      if (xfer) mk = lst ? 0 : mk + 1;
    end
    inj_a[cyc]   = xfer ? a : '0;
    inj_b[cyc]   = xfer ? b : '0;
    start_h[cyc] = st;
    last_h[cyc]  = lst;
    e.rdy = rdy;
    sb.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  function automatic void check(input string nm, input int c,
                                input logic [NN*DW-1:0] act, input logic [NN*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("s_ready", e.cyc, NN*DW'(s_ready), NN*DW'(e.rdy));
        if (e.chk) begin
          check("a_out", e.cyc, a_out, e.a);
          check("b_out", e.cyc, b_out, e.b);
          check("init_out", e.cyc, NN*DW'(init_out), NN*DW'(e.init));
          check("tile_done", e.cyc, NN*DW'(tile_done), NN*DW'(e.done));
          check("busy", e.cyc, NN*DW'(busy), NN*DW'(e.bsy));
`ifdef TILE_FEEDER_CNT_EN
          check("beat_cnt", e.cyc, NN*DW'(beat_cnt), NN*DW'(e.bc));
          check("bubble_cnt", e.cyc, NN*DW'(bubble_cnt), NN*DW'(e.bb));
`endif
        end
      end
    end
  end

  initial begin : driver
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    // three back-to-back beats
    step(0, 1, 0, vec(1, 2, 3, 4), vec(101, 102, 103, 104));
    step(0, 1, 0, vec(5, 6, 7, 8), vec(105, 106, 107, 108));
    step(0, 1, 0, vec(9, 10, 11, 12), vec(109, 110, 111, 112));
    idle(9);
    // two bubbles between beats 1 and 2
    step(0, 1, 0, vec(21, 22, 23, 24), vec(31, 32, 33, 34));
    idle(2);
    step(0, 1, 0, vec(25, 26, 27, 28), vec(35, 36, 37, 38));
    step(0, 1, 0, vec(29, 30, 31, 32), vec(39, 40, 41, 42));
    idle(9);
    // flush alone, then flush racing a beat
    step(0, 0, 1, '0, '0);
    idle(9);
    step(0, 1, 1, vec(41, 42, 43, 44), vec(51, 52, 53, 54));
    step(0, 1, 0, vec(41, 42, 43, 44), vec(51, 52, 53, 54));
    step(0, 1, 0, vec(45, 46, 47, 48), vec(55, 56, 57, 58));
    step(0, 1, 0, vec(49, 50, 51, 52), vec(59, 60, 61, 62));
    idle(9);
    // reset after beat 2 of a tile
    step(0, 1, 0, vec(61, 62, 63, 64), vec(71, 72, 73, 74));
    step(0, 1, 0, vec(65, 66, 67, 68), vec(75, 76, 77, 78));
    step(1, 1, 0, vec(69, 70, 71, 72), vec(79, 80, 81, 82));
    step(0, 1, 0, vec(81, 82, 83, 84), vec(91, 92, 93, 94));
    step(0, 1, 1, vec(85, 86, 87, 88), vec(95, 96, 97, 98));
    step(0, 1, 0, vec(89, 90, 91, 92), vec(99, 100, 101, 102));
    idle(9);
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 60) == 0, ($urandom % 10) < 7, ($urandom % 10) == 0,
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom});
    end
    idle(9);
    @(negedge clk);
    #1;
    check("sb_drained", cyc, NN*DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
